// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared FP format defaults, bias and rounding-mode helpers for sigrnd.
// Used by sigrnd both with and without SIGRND_RMODE_EN.
package fp_pkg;

    localparam int NSIG_DEF = 10;
    localparam int NEXP_DEF = 5;
    localparam int BIAS     = (1 << (NEXP_DEF - 1)) - 1;

    typedef enum logic [1:0] {
        RM_RNE = 2'b00,
        RM_RTZ = 2'b01,
        RM_RUP = 2'b10,
        RM_RDN = 2'b11
    } rmode_e;

    // Increment decision for a positive-magnitude significand given the discarded bits.
    function automatic logic rnd_inc(rmode_e m, logic sign, logic g, logic s, logic lsb);
        case (m)
            RM_RNE:  return g & (s | lsb);
            RM_RTZ:  return 1'b0;
            RM_RUP:  return (g | s) & ~sign;
            default: return (g | s) & sign;
        endcase
    endfunction

    // Modes that never round toward infinity for this sign saturate to max finite.
    function automatic logic ovf_to_max(rmode_e m, logic sign);
        case (m)
            RM_RNE:  return 1'b0;
            RM_RTZ:  return 1'b1;
            RM_RUP:  return sign;
            default: return ~sign;
        endcase
    endfunction

endpackage

// File: rtl/fp_norm.sv
// rtl/fp_norm.sv - combinational normalizer: picks the 1.x window of the raw product,
// extracts guard/sticky and adjusts the exponent.
module fp_norm
    import fp_pkg::*;
#(
    parameter int NSIG = NSIG_DEF,
    parameter int NEXP = NEXP_DEF
) (
    input  logic [2*NSIG+1:0] prod,
    input  logic [NEXP+1:0]   exp_in,
    output logic [NSIG:0]     mant,
    output logic              guard,
    output logic              sticky,
    output logic [NEXP+2:0]   exp_n,
    output logic              is_zero
);

    logic [NEXP+2:0] exp_ext;

    always_comb begin
        // One extra bit so the +1 here and the rounding carry later cannot wrap.
        exp_ext = {exp_in[NEXP+1], exp_in};
        is_zero = (prod[2*NSIG+1:2*NSIG] == 2'b00);
        mant    = prod[2*NSIG:NSIG];
        guard   = prod[NSIG-1];
        sticky  = |prod[NSIG-2:0];
        exp_n   = exp_ext;
        if (prod[2*NSIG+1]) begin
            mant   = prod[2*NSIG+1:NSIG+1];
            guard  = prod[NSIG];
            sticky = |prod[NSIG-1:0];
            exp_n  = exp_ext + {{(NEXP+2){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/sigrnd.sv
// rtl/sigrnd.sv - 2-stage significand normalize/round/range-check pipeline with valid/ready.
// Define SIGRND_RMODE_EN to add the rm[1:0] rounding-mode input (default build is RNE only).
module sigrnd
    import fp_pkg::*;
#(
    parameter int NSIG = NSIG_DEF,
    parameter int NEXP = NEXP_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2*NSIG+1:0] prod,
    input  logic [NEXP+1:0]   exp_in,
    input  logic              sign_in,
`ifdef SIGRND_RMODE_EN
    input  logic [1:0]        rm,
`endif
    output logic              out_valid,
    input  logic              out_ready,
    output logic              sign_out,
    output logic [NEXP-1:0]   exp_out,
    output logic [NSIG-1:0]   frac_out,
    output logic              overflow,
    output logic              underflow,
    output logic              inexact
);

    localparam logic [NEXP+2:0] EXP_ALL1 = (NEXP+3)'((1 << NEXP) - 1);

    logic [NSIG:0]   n_mant;
    logic            n_guard, n_sticky, n_zero;
    logic [NEXP+2:0] n_exp;

    fp_norm #(.NSIG(NSIG), .NEXP(NEXP)) u_norm (
        .prod    (prod),
        .exp_in  (exp_in),
        .mant    (n_mant),
        .guard   (n_guard),
        .sticky  (n_sticky),
        .exp_n   (n_exp),
        .is_zero (n_zero)
    );

    logic            s1_full_q, s1_full_d;
    logic [NSIG:0]   s1_mant_q, s1_mant_d;
    logic            s1_guard_q, s1_guard_d;
    logic            s1_sticky_q, s1_sticky_d;
    logic [NEXP+2:0] s1_exp_q, s1_exp_d;
    logic            s1_sign_q, s1_sign_d;
    logic            s1_zero_q, s1_zero_d;
`ifdef SIGRND_RMODE_EN
    rmode_e          s1_rm_q, s1_rm_d;
`endif

    logic            s2_full_q, s2_full_d;
    logic            sign_q, sign_d;
    logic [NEXP-1:0] exp_q, exp_d;
    logic [NSIG-1:0] frac_q, frac_d;
    logic            ovf_q, ovf_d;
    logic            unf_q, unf_d;
    logic            inx_q, inx_d;

    logic            s2_can;
    logic            in_fire;
    rmode_e          mode;
    logic            inc;
    logic [NSIG+1:0] sum;
    logic            carry;
    logic [NEXP+2:0] exp_r;
    logic            r_ovf, r_unf;
    logic [NEXP-1:0] r_exp;
    logic [NSIG-1:0] r_frac;
    logic            r_ovf_f, r_unf_f, r_inx;

    assign s2_can   = !s2_full_q || out_ready;
    assign in_ready = !rst && (!s1_full_q || s2_can);
    assign in_fire  = in_valid && in_ready;

    // Stage 2 datapath: round, renormalize on carry-out, then range check.
    always_comb begin
`ifdef SIGRND_RMODE_EN
        mode = s1_rm_q;
`else
        mode = RM_RNE;
`endif
        inc     = rnd_inc(mode, s1_sign_q, s1_guard_q, s1_sticky_q, s1_mant_q[0]);
        sum     = {1'b0, s1_mant_q} + {{(NSIG+1){1'b0}}, inc};
        carry   = sum[NSIG+1];
        exp_r   = s1_exp_q + {{(NEXP+2){1'b0}}, carry};
        r_ovf   = !exp_r[NEXP+2] && (exp_r >= EXP_ALL1);
        r_unf   = exp_r[NEXP+2] || (exp_r == '0);
        r_exp   = exp_r[NEXP-1:0];
        r_frac  = carry ? '0 : sum[NSIG-1:0];
        r_ovf_f = 1'b0;
        r_unf_f = 1'b0;
        r_inx   = s1_guard_q | s1_sticky_q;
        if (s1_zero_q) begin
            r_exp  = '0;
            r_frac = '0;
            r_inx  = 1'b0;
        end else if (r_ovf) begin
            r_ovf_f = 1'b1;
            r_inx   = 1'b1;
            if (ovf_to_max(mode, s1_sign_q)) begin
                r_exp  = {{(NEXP-1){1'b1}}, 1'b0};
                r_frac = '1;
            end else begin
                r_exp  = '1;
                r_frac = '0;
            end
        end else if (r_unf) begin
            r_unf_f = 1'b1;
            r_inx   = 1'b1;
            r_exp   = '0;
            r_frac  = '0;
        end
    end

    always_comb begin
        s1_mant_d   = s1_mant_q;
        s1_guard_d  = s1_guard_q;
        s1_sticky_d = s1_sticky_q;
        s1_exp_d    = s1_exp_q;
        s1_sign_d   = s1_sign_q;
        s1_zero_d   = s1_zero_q;
`ifdef SIGRND_RMODE_EN
        s1_rm_d     = s1_rm_q;
`endif
        s2_full_d   = s2_full_q;
        sign_d      = sign_q;
        exp_d       = exp_q;
        frac_d      = frac_q;
        ovf_d       = ovf_q;
        unf_d       = unf_q;
        inx_d       = inx_q;

        s1_full_d = in_fire || (s1_full_q && !s2_can);
        if (in_fire) begin
            s1_mant_d   = n_mant;
            s1_guard_d  = n_guard;
            s1_sticky_d = n_sticky;
            s1_exp_d    = n_exp;
            s1_sign_d   = sign_in;
            s1_zero_d   = n_zero;
`ifdef SIGRND_RMODE_EN
            s1_rm_d     = rmode_e'(rm);
`endif
        end

        // S2 only changes when its current result has been taken or it is empty.
        if (s2_can) begin
            s2_full_d = s1_full_q;
            if (s1_full_q) begin
                sign_d = s1_sign_q;
                exp_d  = r_exp;
                frac_d = r_frac;
                ovf_d  = r_ovf_f;
                unf_d  = r_unf_f;
                inx_d  = r_inx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_full_q   <= 1'b0;
            s1_mant_q   <= '0;
            s1_guard_q  <= 1'b0;
            s1_sticky_q <= 1'b0;
            s1_exp_q    <= '0;
            s1_sign_q   <= 1'b0;
            s1_zero_q   <= 1'b0;
`ifdef SIGRND_RMODE_EN
            s1_rm_q     <= RM_RNE;
`endif
            s2_full_q   <= 1'b0;
            sign_q      <= 1'b0;
            exp_q       <= '0;
            frac_q      <= '0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
            inx_q       <= 1'b0;
        end else begin
            s1_full_q   <= s1_full_d;
            s1_mant_q   <= s1_mant_d;
            s1_guard_q  <= s1_guard_d;
            s1_sticky_q <= s1_sticky_d;
            s1_exp_q    <= s1_exp_d;
            s1_sign_q   <= s1_sign_d;
            s1_zero_q   <= s1_zero_d;
`ifdef SIGRND_RMODE_EN
            s1_rm_q     <= s1_rm_d;
`endif
            s2_full_q   <= s2_full_d;
            sign_q      <= sign_d;
            exp_q       <= exp_d;
            frac_q      <= frac_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
            inx_q       <= inx_d;
        end
    end

    assign out_valid = s2_full_q;
    assign sign_out  = sign_q;
    assign exp_out   = exp_q;
    assign frac_out  = frac_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;
    assign inexact   = inx_q;

endmodule

// File: tb/tb_sigrnd.sv
// tb/tb_sigrnd.sv - self-checking bench for sigrnd (default RNE build): vector table,
// randomized back-pressure stream against an arithmetic reference, and reset flush.
module tb_sigrnd;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [21:0] prod;
    logic [6:0]  exp_in;
    logic        sign_in;
    logic        out_valid, out_ready;
    logic        sign_out, overflow, underflow, inexact;
    logic [4:0]  exp_out;
    logic [9:0]  frac_out;
    logic [18:0] res;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    sigrnd dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .prod      (prod),
        .exp_in    (exp_in),
        .sign_in   (sign_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sign_out  (sign_out),
        .exp_out   (exp_out),
        .frac_out  (frac_out),
        .overflow  (overflow),
        .underflow (underflow),
        .inexact   (inexact)
    );

    assign res = {sign_out, exp_out, frac_out, overflow, underflow, inexact};

    typedef struct {
        logic [21:0] prod;
        logic [6:0]  exp_in;
        logic        sign;
        logic [18:0] res;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, req);
    endtask

    function automatic logic [18:0] mkres(logic s, logic [4:0] e, logic [9:0] f,
                                          logic o, logic u, logic i);
        return {s, e, f, o, u, i};
    endfunction

    // Reference: value-level rounding of prod / 2^sh to nearest-even.
    function automatic logic [18:0] model(logic [21:0] p, logic signed [6:0] e, logic s);
        int sh, mant, rem, half, ei, f;
        bit up, inx;
        if (p[21:20] == 2'b00) return {s, 18'b0};
        sh   = p[21] ? 11 : 10;
        mant = int'(p) >> sh;
        rem  = int'(p) - (mant << sh);
        half = 1 << (sh - 1);
        up   = (rem > half) || (rem == half && (mant % 2) == 1);
        ei   = int'(e) + (p[21] ? 1 : 0);
        mant = mant + (up ? 1 : 0);
        if (mant == 2048) begin
            mant = 1024;
            ei   = ei + 1;
        end
        inx = (rem != 0);
        if (ei >= 31) return mkres(s, 5'h1F, 10'h0, 1'b1, 1'b0, 1'b1);
        if (ei <= 0)  return mkres(s, 5'h0, 10'h0, 1'b0, 1'b1, 1'b1);
        f = mant - 1024;
        return mkres(s, ei[4:0], f[9:0], 1'b0, 1'b0, inx);
    endfunction

    task automatic run_vec(input vec_t v, input int idx);
        @(negedge clk);
        prod      = v.prod;
        exp_in    = v.exp_in;
        sign_in   = v.sign;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1 chk($sformatf("vec%0d_in_ready", idx), 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk($sformatf("vec%0d_out_valid_cycle1", idx), 32'(out_valid), 32'd0);
        @(negedge clk);
        chk($sformatf("vec%0d_out_valid_cycle2", idx), 32'(out_valid), 32'd1);
        chk($sformatf("vec%0d_result", idx), 32'(res), 32'(v.res));
    endtask

    task automatic new_beat(output logic [21:0] p, output logic [6:0] e, output logic s);
        int t;
        p = 22'($urandom);
        t = $urandom_range(0, 37);
        e = 7'(t - 3);
        s = 1'($urandom_range(0, 1));
    endtask

    task automatic run_stream(input int n, input int vprob);
        logic [18:0] q[$];
        logic [18:0] hold;
        logic        have_hold;
        logic [21:0] cp;
        logic [6:0]  ce;
        logic        cs;
        int sent, got, inflight, cyc, extra;
        sent = 0; got = 0; inflight = 0; cyc = 0; extra = 0;
        have_hold = 1'b0;
        hold = '0;
        new_beat(cp, ce, cs);
        while (got < n && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            out_ready = 1'($urandom_range(0, 1));
            in_valid  = (sent < n) && ($urandom_range(1, 100) <= vprob);
            prod      = cp;
            exp_in    = ce;
            sign_in   = cs;
            #1;
            if (have_hold)
                chk("stall_hold", {13'b0, out_valid, res}, {13'b0, 1'b1, hold});
            chk("in_ready_occupancy", 32'(in_ready), 32'(!(inflight == 2 && !out_ready)));
            have_hold = out_valid && !out_ready;
            hold      = res;
            if (out_valid && out_ready) begin
                if (q.size() == 0) chk("unexpected_output", 32'd1, 32'd0);
                else chk($sformatf("stream_result%0d", got), 32'(res), 32'(q.pop_front()));
                got++;
                inflight--;
            end
            if (in_valid && in_ready) begin
                q.push_back(model(cp, ce, cs));
                sent++;
                inflight++;
                new_beat(cp, ce, cs);
            end
        end
        in_valid = 1'b0;
        chk("stream_count", 32'(got), 32'(n));
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (out_valid) extra++;
        end
        chk("stream_no_duplicate", 32'(extra), 32'd0);
    endtask

    initial begin
        int seen;
        vecs[0]  = '{22'h240000, 7'd15, 1'b0, mkres(1'b0, 5'd16, 10'h080, 1'b0, 1'b0, 1'b0)};
        vecs[1]  = '{22'h100200, 7'd15, 1'b0, mkres(1'b0, 5'd15, 10'h000, 1'b0, 1'b0, 1'b1)};
        vecs[2]  = '{22'h100600, 7'd15, 1'b0, mkres(1'b0, 5'd15, 10'h002, 1'b0, 1'b0, 1'b1)};
        vecs[3]  = '{22'h1FFE00, 7'd15, 1'b0, mkres(1'b0, 5'd16, 10'h000, 1'b0, 1'b0, 1'b1)};
        vecs[4]  = '{22'h200000, 7'd30, 1'b0, mkres(1'b0, 5'h1F, 10'h000, 1'b1, 1'b0, 1'b1)};
        vecs[5]  = '{22'h100000, 7'd0,  1'b0, mkres(1'b0, 5'd0,  10'h000, 1'b0, 1'b1, 1'b1)};
        vecs[6]  = '{22'h0FFFFF, 7'd10, 1'b1, mkres(1'b1, 5'd0,  10'h000, 1'b0, 1'b0, 1'b0)};
        vecs[7]  = '{22'h240000, 7'd3,  1'b1, mkres(1'b1, 5'd4,  10'h080, 1'b0, 1'b0, 1'b0)};
        vecs[8]  = '{22'h240000, 7'h7B, 1'b0, mkres(1'b0, 5'd0,  10'h000, 1'b0, 1'b1, 1'b1)};
        vecs[9]  = '{22'h240000, 7'd29, 1'b1, mkres(1'b1, 5'd30, 10'h080, 1'b0, 1'b0, 1'b0)};
        vecs[10] = '{22'h1FFE00, 7'd30, 1'b0, mkres(1'b0, 5'h1F, 10'h000, 1'b1, 1'b0, 1'b1)};
        vecs[11] = '{22'h100201, 7'd15, 1'b0, mkres(1'b0, 5'd15, 10'h001, 1'b0, 1'b0, 1'b1)};
        vecs[12] = '{22'h100001, 7'd15, 1'b0, mkres(1'b0, 5'd15, 10'h000, 1'b0, 1'b0, 1'b1)};
        vecs[13] = '{22'h200801, 7'd15, 1'b0, mkres(1'b0, 5'd16, 10'h001, 1'b0, 1'b0, 1'b1)};
        vecs[14] = '{22'h100000, 7'd1,  1'b1, mkres(1'b1, 5'd1,  10'h000, 1'b0, 1'b0, 1'b0)};
        vecs[15] = '{22'h200000, 7'd29, 1'b0, mkres(1'b0, 5'd30, 10'h000, 1'b0, 1'b0, 1'b0)};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        prod = '0; exp_in = '0; sign_in = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_in_ready", 32'(in_ready), 32'd0);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        rst = 1'b0;
        #1;
        chk("post_reset_in_ready", 32'(in_ready), 32'd1);
        chk("post_reset_outputs", 32'(res), 32'd0);

        for (int i = 0; i < 16; i++) run_vec(vecs[i], i);

        run_stream(8, 100);
        run_stream(200, 70);

        // Reset with two beats in flight.
        @(negedge clk);
        out_ready = 1'b0;
        prod = 22'h240000; exp_in = 7'd15; sign_in = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        prod = 22'h300000; exp_in = 7'd10; sign_in = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("flush_pre_out_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        #1 chk("flush_rst_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        rst = 1'b0;
        out_ready = 1'b1;
        #1 chk("flush_in_ready", 32'(in_ready), 32'd1);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("flush_no_ghost", 32'(seen), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

endmodule
